// File: rtl/coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : coef_loader
// Description : Streams a z0/z1 coefficient frame into a shadow register,
//               range-checks the pairwise differences and commits the set to
//               the solver buses, holding the solver in reset while it settles.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_loader #(
    parameter int NCOEF  = 12,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [1:0]           s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [2*NCOEF-1:0]   z0_bus,
    output logic [2*NCOEF-1:0]   z1_bus,
    output logic                 solver_rst,
    output logic                 coef_valid,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int         c_w           = 2 * NCOEF;
    localparam logic [4:0] c_last_beat   = 5'(2 * NCOEF - 1);
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);
    localparam logic [1:0] c_err_early   = 2'b01;
    localparam logic [1:0] c_err_missing = 2'b10;
    localparam logic [1:0] c_err_range   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_ret;
    logic [4:0]         r_cnt;
    logic [3:0]         r_settle;
    logic [2*c_w-1:0]   r_shadow;       // z0 beats in the low half, z1 in the high half
    logic               r_committed;
    logic [c_w-1:0]     r_z0;
    logic [c_w-1:0]     r_z1;
    logic               r_solver_rst;
    logic               r_coef_valid;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic               w_ready;
    logic               w_accept;
    logic               w_commit;
    logic               w_err_set;
    logic [1:0]         w_err_code_nxt;
    logic [NCOEF-1:0]   w_k_ok;

    assign w_ready  = ((r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_RUN)) && !reset;
    assign w_accept = s_valid && w_ready;

    genvar k;
    generate
        for (k = 0; k < NCOEF; k++) begin : g_range
            logic signed [3:0] w_d;
            assign w_d = {{2{r_shadow[c_w+2*k+1]}}, r_shadow[c_w+2*k +: 2]}
                       - {{2{r_shadow[2*k+1]}}, r_shadow[2*k +: 2]};
            assign w_k_ok[k] = (w_d >= -4'sd2) && (w_d <= 4'sd2);
        end
    endgenerate

    always_comb begin
        w_state_nxt    = r_state;
        w_commit       = 1'b0;
        w_err_set      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_ret          = r_committed ? ST_RUN : ST_IDLE;
        case (r_state)
            ST_IDLE, ST_LOAD, ST_RUN: begin
                if (w_accept) begin
                    if (r_cnt == c_last_beat) begin
                        if (s_last) begin
                            w_state_nxt = ST_CHECK;
                        end else begin
                            w_err_set      = 1'b1;
                            w_err_code_nxt = c_err_missing;
                            w_state_nxt    = w_ret;
                        end
                    end else if (s_last) begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = c_err_early;
                        w_state_nxt    = w_ret;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_CHECK: begin
                if (&w_k_ok) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = c_err_range;
                    w_state_nxt    = w_ret;
                end
            end
            ST_ARM: begin
                if (r_settle == c_settle_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 5'd0;
            r_settle     <= 4'd0;
            r_shadow     <= '0;
            r_committed  <= 1'b0;
            r_z0         <= '0;
            r_z1         <= '0;
            r_solver_rst <= 1'b1;
            r_coef_valid <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_err_set;
            r_err_code <= w_err_code_nxt;
            if (w_accept) begin
                for (int i = 0; i < 2 * NCOEF; i++) begin
                    if (r_cnt == 5'(i)) begin
                        r_shadow[2*i +: 2] <= s_data;
                    end
                end
                r_cnt <= (w_state_nxt == ST_LOAD) ? r_cnt + 5'd1 : 5'd0;
            end
            r_settle <= (r_state == ST_ARM) ? r_settle + 4'd1 : 4'd0;
            if (w_commit) begin
                r_z0        <= r_shadow[c_w-1:0];
                r_z1        <= r_shadow[2*c_w-1:c_w];
                r_committed <= 1'b1;
            end
            // Solver-facing flags follow the state one cycle later.
            r_solver_rst <= (r_state == ST_ARM) || ((r_state == ST_IDLE) && !r_committed);
            r_coef_valid <= (r_state == ST_RUN)
                         || (((r_state == ST_LOAD) || (r_state == ST_CHECK)) && r_committed);
        end
    end

    assign s_ready    = w_ready;
    assign z0_bus     = r_z0;
    assign z1_bus     = r_z1;
    assign solver_rst = r_solver_rst;
    assign coef_valid = r_coef_valid;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_coef_loader
// Description : Self-checking bench for coef_loader: vector table, reset
//               corner sequences and random frames against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_loader;

    localparam int NCOEF  = 12;
    localparam int SETTLE = 2;
    localparam int W      = 2 * NCOEF;
    localparam int NB     = 2 * NCOEF;
    localparam int NV     = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic [1:0]   s_data = 2'b00;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [W-1:0] z0_bus;
    logic [W-1:0] z1_bus;
    logic         solver_rst;
    logic         coef_valid;
    logic         err;
    logic [1:0]   err_code;

    coef_loader #(.NCOEF(NCOEF), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .z0_bus     (z0_bus),
        .z1_bus     (z1_bus),
        .solver_rst (solver_rst),
        .coef_valid (coef_valid),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z0;
        logic [W-1:0] z1;
        int           lastpos;   // -1: no s_last in the frame
        int           gap;       // 0 none, 1 every other cycle, 2 random
        logic [1:0]   code;      // 0 = commit
        logic [W-1:0] ez0;
        logic [W-1:0] ez1;
    } vec_t;

    vec_t         vt [NV];
    int           total = 0;
    int           bad = 0;
    logic [1:0]   f_data [NB];
    logic         f_last [NB];
    int           f_len;
    logic [W-1:0] cur_z0;
    logic [W-1:0] cur_z1;
    logic         committed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_last(input int lastpos);
        for (int i = 0; i < NB; i++) f_last[i] = (i == lastpos);
        f_len = (lastpos >= 0 && lastpos < NB) ? lastpos + 1 : NB;
    endtask

    task automatic fill_frame(input logic [W-1:0] z0, input logic [W-1:0] z1, input int lastpos);
        for (int k = 0; k < NCOEF; k++) begin
            f_data[k]         = z0[2*k +: 2];
            f_data[NCOEF + k] = z1[2*k +: 2];
        end
        set_last(lastpos);
    endtask

    function automatic int sval(input logic [1:0] v);
        return v[1] ? int'(v) - 4 : int'(v);
    endfunction

    // Frame-level reference: outcome code and the buses expected afterwards.
    task automatic model(output logic [1:0] code, output logic [W-1:0] ez0, output logic [W-1:0] ez1);
        int d;
        code = 2'b00;
        ez0  = cur_z0;
        ez1  = cur_z1;
        for (int i = 0; i < NB - 1; i++) begin
            if (f_last[i]) begin
                code = 2'b01;
                return;
            end
        end
        if (!f_last[NB-1]) begin
            code = 2'b10;
            return;
        end
        for (int k = 0; k < NCOEF; k++) begin
            d = sval(f_data[NCOEF + k]) - sval(f_data[k]);
            if (d < -2 || d > 2) begin
                code = 2'b11;
                return;
            end
        end
        for (int k = 0; k < NCOEF; k++) begin
            ez0[2*k +: 2] = f_data[k];
            ez1[2*k +: 2] = f_data[NCOEF + k];
        end
    endtask

    task automatic run_frame(input int gap, input logic [1:0] code,
                             input logic [W-1:0] ez0, input logic [W-1:0] ez1);
        int waited = 0;
        while (!s_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("ready_before_frame", s_ready, 1);
        for (int i = 0; i < f_len; i++) begin
            if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(2) == 0))) begin
                s_valid = 1'b0;
                s_data  = 2'($urandom);
                s_last  = 1'($urandom);
                tick();
                chk("idle_err", err, 0);
                chk("idle_z0", z0_bus, cur_z0);
                chk("idle_z1", z1_bus, cur_z1);
            end
            chk("beat_ready", s_ready, 1);
            s_valid = 1'b1;
            s_data  = f_data[i];
            s_last  = f_last[i];
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i < f_len - 1) begin
                chk("load_err", err, 0);
                chk("load_z0_hold", z0_bus, cur_z0);
                chk("load_z1_hold", z1_bus, cur_z1);
                chk("load_coef_valid", coef_valid, committed);
            end
        end
        if (code == 2'b01 || code == 2'b10) begin
            chk("framing_err", err, 1);
            chk("framing_code", err_code, code);
            chk("framing_z0", z0_bus, ez0);
            chk("framing_z1", z1_bus, ez1);
            tick();
            chk("framing_err_once", err, 0);
            chk("framing_code_held", err_code, code);
            chk("framing_ret_ready", s_ready, 1);
            chk("framing_ret_coef_valid", coef_valid, committed);
            chk("framing_ret_solver_rst", solver_rst, !committed);
        end else begin
            chk("check_ready", s_ready, 0);
            chk("check_err", err, 0);
            tick();
            if (code == 2'b11) begin
                chk("range_err", err, 1);
                chk("range_code", err_code, 2'b11);
                chk("range_z0", z0_bus, ez0);
                chk("range_z1", z1_bus, ez1);
                tick();
                chk("range_err_once", err, 0);
                chk("range_code_held", err_code, 2'b11);
                chk("range_ret_ready", s_ready, 1);
                chk("range_ret_coef_valid", coef_valid, committed);
                chk("range_ret_solver_rst", solver_rst, !committed);
            end else begin
                chk("arm_ready", s_ready, 0);
                chk("arm_err", err, 0);
                chk("commit_z0", z0_bus, ez0);
                chk("commit_z1", z1_bus, ez1);
                for (int j = 0; j < SETTLE; j++) begin
                    tick();
                    chk("settle_solver_rst", solver_rst, 1);
                    chk("settle_coef_valid", coef_valid, 0);
                end
                tick();
                chk("run_solver_rst", solver_rst, 0);
                chk("run_coef_valid", coef_valid, 1);
                chk("run_ready", s_ready, 1);
                chk("run_z0", z0_bus, ez0);
                chk("run_z1", z1_bus, ez1);
                cur_z0    = ez0;
                cur_z1    = ez1;
                committed = 1'b1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   code;
        logic [W-1:0] ez0;
        logic [W-1:0] ez1;
        int           lastpos;
        int           sel;

        vt[0]  = '{24'h000000, 24'h555555, 10, 0, 2'b01, 24'h000000, 24'h000000};
        vt[1]  = '{24'h000000, 24'h555555, 23, 0, 2'b00, 24'h000000, 24'h555555};
        vt[2]  = '{24'h000000, 24'h555555, 23, 1, 2'b00, 24'h000000, 24'h555555};
        vt[3]  = '{24'h000010, 24'h555565, 23, 0, 2'b11, 24'h000000, 24'h555555};
        vt[4]  = '{24'hFFFFFF, 24'h000000, 23, 0, 2'b00, 24'hFFFFFF, 24'h000000};
        vt[5]  = '{24'h000000, 24'h555555, -1, 2, 2'b10, 24'hFFFFFF, 24'h000000};
        vt[6]  = '{24'hFFFFFF, 24'h555555, 23, 2, 2'b00, 24'hFFFFFF, 24'h555555};
        vt[7]  = '{24'h555555, 24'hFFFFFF, 23, 0, 2'b00, 24'h555555, 24'hFFFFFF};
        vt[8]  = '{24'hAAAAAA, 24'h555555, 23, 1, 2'b11, 24'h555555, 24'hFFFFFF};
        vt[9]  = '{24'h000000, 24'h000000,  0, 0, 2'b01, 24'h555555, 24'hFFFFFF};
        vt[10] = '{24'h000000, 24'h000000, 22, 0, 2'b01, 24'h555555, 24'hFFFFFF};
        vt[11] = '{24'hAAAAAA, 24'h000000, 23, 0, 2'b00, 24'hAAAAAA, 24'h000000};

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_solver_rst", solver_rst, 1);
        chk("rst_coef_valid", coef_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_z0", z0_bus, 0);
        chk("rst_z1", z1_bus, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", s_ready, 1);
        chk("idle_solver_rst", solver_rst, 1);
        chk("idle_coef_valid", coef_valid, 0);
        cur_z0    = '0;
        cur_z1    = '0;
        committed = 1'b0;

        for (int v = 0; v < NV; v++) begin
            fill_frame(vt[v].z0, vt[v].z1, vt[v].lastpos);
            run_frame(vt[v].gap, vt[v].code, vt[v].ez0, vt[v].ez1);
        end

        // Reset landing on beat 15 of a replacement frame.
        fill_frame(24'h000000, 24'h555555, 23);
        for (int i = 0; i < 15; i++) begin
            s_valid = 1'b1;
            s_data  = f_data[i];
            s_last  = 1'b0;
            tick();
        end
        s_data = f_data[15];
        reset  = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("rst15_ready", s_ready, 0);
        chk("rst15_solver_rst", solver_rst, 1);
        chk("rst15_coef_valid", coef_valid, 0);
        chk("rst15_z0", z0_bus, 0);
        chk("rst15_z1", z1_bus, 0);
        chk("rst15_err", err, 0);
        reset = 1'b0;
        tick();
        chk("rst15_idle_ready", s_ready, 1);
        chk("rst15_idle_solver_rst", solver_rst, 1);
        chk("rst15_idle_err", err, 0);
        cur_z0    = '0;
        cur_z1    = '0;
        committed = 1'b0;
        fill_frame(24'h000000, 24'h555555, 23);
        run_frame(0, 2'b00, 24'h000000, 24'h555555);

        // Reset during ARM abandons the commit.
        fill_frame(24'hFFFFFF, 24'h000000, 23);
        for (int i = 0; i < NB; i++) begin
            s_valid = 1'b1;
            s_data  = f_data[i];
            s_last  = f_last[i];
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        chk("arm_rst_pre_ready", s_ready, 0);
        reset = 1'b1;
        tick();
        chk("arm_rst_err", err, 0);
        chk("arm_rst_z0", z0_bus, 0);
        chk("arm_rst_z1", z1_bus, 0);
        chk("arm_rst_solver_rst", solver_rst, 1);
        reset = 1'b0;
        repeat (SETTLE + 3) tick();
        chk("arm_rst_coef_valid", coef_valid, 0);
        chk("arm_rst_solver_rst_held", solver_rst, 1);
        chk("arm_rst_ready", s_ready, 1);
        chk("arm_rst_err_after", err, 0);
        cur_z0    = '0;
        cur_z1    = '0;
        committed = 1'b0;

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NB; i++) f_data[i] = 2'($urandom);
            sel = $urandom_range(9);
            if (sel < 7)      lastpos = NB - 1;
            else if (sel < 9) lastpos = $urandom_range(NB - 2);
            else              lastpos = -1;
            set_last(lastpos);
            model(code, ez0, ez1);
            run_frame($urandom_range(2), code, ez0, ez1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
